eth_rx_frame_buf: RTL

Receive frame-buffer controller between the RMII receive path and the user logic. Accepts the byte stream and end-of-frame CRC verdict from the receive datapath, writes bytes into a circular byte RAM, and commits or discards each frame. Committed frames, stripped of the 4-byte FCS, are replayed to the consumer on a valid/ready byte stream with a last-byte marker.

---
 rtl/eth_rx_frame_buf_pkg.sv | 26 ++
 rtl/eth_rx_frame_buf_if.sv | 35 +++
 rtl/eth_rx_buf_ram.sv | 38 +++
 rtl/eth_rx_frame_buf.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_frame_buf_pkg.sv
// ---------------------------------------------------------------------------
// eth_rx_frame_buf_pkg
// Shared definitions for the Ethernet receive frame buffer:
//   - write-FSM and read-FSM state encodings
//   - FCS length in bytes
//   - default minimum accepted frame length (FCS included)
// No ports; imported by the top and its sub-module.
// ---------------------------------------------------------------------------
package eth_rx_frame_buf_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RECV = 2'd1,
    W_DROP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_LOAD   = 2'd1,
    R_STREAM = 2'd2
  } rd_state_t;

  localparam int FCS_LEN     = 4;
  localparam int DEF_MIN_LEN = 64;

endpackage

// File: rtl/eth_rx_frame_buf_if.sv
// ---------------------------------------------------------------------------
// eth_rx_frame_buf_if
// Groups the receive byte stream (from the RMII datapath) and the frame
// output stream (to the user logic).
//   Rx_Frame_Active  frame in progress
//   Rx_Byte_Rdy      one-cycle byte strobe
//   Rx_Byte          received byte
//   Rx_Crc_Valid     CRC verdict, valid on the falling edge of Rx_Frame_Active
//   Frm_Tvalid/Frm_Tdata/Frm_Tlast/Frm_Tready  output byte stream
// Modports:
//   slave  - the frame buffer (consumes Rx_*, produces Frm_*)
//   master - the environment (drives Rx_* and Frm_Tready)
// ---------------------------------------------------------------------------
interface eth_rx_frame_buf_if;

  logic       Rx_Frame_Active;
  logic       Rx_Byte_Rdy;
  logic [7:0] Rx_Byte;
  logic       Rx_Crc_Valid;
  logic       Frm_Tvalid;
  logic [7:0] Frm_Tdata;
  logic       Frm_Tlast;
  logic       Frm_Tready;

  modport slave (
    input  Rx_Frame_Active, Rx_Byte_Rdy, Rx_Byte, Rx_Crc_Valid, Frm_Tready,
    output Frm_Tvalid, Frm_Tdata, Frm_Tlast
  );

  modport master (
    output Rx_Frame_Active, Rx_Byte_Rdy, Rx_Byte, Rx_Crc_Valid, Frm_Tready,
    input  Frm_Tvalid, Frm_Tdata, Frm_Tlast
  );

endinterface

// File: rtl/eth_rx_buf_ram.sv
// ---------------------------------------------------------------------------
// eth_rx_buf_ram
// Simple dual-port byte RAM: one write port, one registered read port.
// Depth 2^pADDR_W bytes. Read data updates only when i_Re is high, so the
// output holds its value while the consumer stalls.
// Ports:
//   i_Clk            clock
//   i_We/i_Waddr/i_Wdata   write port
//   i_Re/i_Raddr     read request
//   o_Rdata          registered read data (one cycle after i_Re)
// ---------------------------------------------------------------------------
module eth_rx_buf_ram #(
  parameter int pADDR_W = 11
) (
  input  logic               i_Clk,
  input  logic               i_We,
  input  logic [pADDR_W-1:0] i_Waddr,
  input  logic [7:0]         i_Wdata,
  input  logic               i_Re,
  input  logic [pADDR_W-1:0] i_Raddr,
  output logic [7:0]         o_Rdata
);

  logic [7:0] r_mem [2**pADDR_W];
  logic [7:0] r_rdata_p1;

  always_ff @(posedge i_Clk) begin
    if (i_We) r_mem[i_Waddr] <= i_Wdata;
  end

  // read stage: address -> registered data
  always_ff @(posedge i_Clk) begin
    if (i_Re) r_rdata_p1 <= r_mem[i_Raddr];
  end

  assign o_Rdata = r_rdata_p1;

endmodule

// File: rtl/eth_rx_frame_buf.sv
// ---------------------------------------------------------------------------
// eth_rx_frame_buf
// Receive frame buffer between the RMII receive path and user logic.
// Received bytes are written into a circular byte RAM at a candidate
// pointer; at end of frame the frame is committed (length pushed into an
// inline length FIFO, committed pointer advanced past the payload) or
// discarded. Committed frames are replayed without their FCS on a
// valid/ready byte stream with a last-byte marker.
//
// Ports:
//   Clk, Rst     clock, synchronous active-high reset
//   bus          eth_rx_frame_buf_if.slave (Rx_* in, Frm_* out)
//   Frm_Pending  committed frames not yet fully read
//   Drop_Pulse   one-cycle pulse per discarded frame
//   Good_Cnt, Crc_Err_Cnt, Ovf_Cnt   16-bit saturating statistics,
//                present only when ETH_RX_STATS_EN is defined
// ---------------------------------------------------------------------------
module eth_rx_frame_buf
  import eth_rx_frame_buf_pkg::*;
#(
  parameter int pADDR_W  = 11,
  parameter int pLEN_AW  = 3,
  parameter int pMIN_LEN = DEF_MIN_LEN
) (
  input  logic                Clk,
  input  logic                Rst,
  eth_rx_frame_buf_if.slave   bus,
  output logic [pLEN_AW:0]    Frm_Pending,
  output logic                Drop_Pulse
`ifdef ETH_RX_STATS_EN
  ,
  output logic [15:0]         Good_Cnt,
  output logic [15:0]         Crc_Err_Cnt,
  output logic [15:0]         Ovf_Cnt
`endif
);

  localparam int CW = pADDR_W + 1;
  localparam int FW = pLEN_AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(1 << pADDR_W);
  localparam logic [CW-1:0] MIN_CNT   = CW'(pMIN_LEN);
  localparam logic [CW-1:0] FCS_C     = CW'(FCS_LEN);
  localparam logic [FW-1:0] FIFO_FULL = FW'(1 << pLEN_AW);

  // write side
  wr_state_t          r_wr_state, w_wr_nxt;
  logic               r_fa_d;
  logic [pADDR_W-1:0] r_wr_ptr, r_cand_ptr, w_base_ptr;
  logic [CW-1:0]      r_cnt, w_base_cnt, r_used, w_free;
  logic               w_rise, w_fall, w_take, w_we;
  logic               w_end_recv, w_end_drop, w_ok;
  logic               r_commit, r_drop;
  logic [CW-1:0]      r_clen;

  // length FIFO
  logic [CW-1:0]      r_lfifo [2**pLEN_AW];
  logic [pLEN_AW-1:0] r_fwr, r_frd;
  logic [FW-1:0]      r_fcnt, r_pend;
  logic               w_fifo_full, w_fifo_empty;

  // read side
  rd_state_t          r_rd_state, w_rd_nxt;
  logic [pADDR_W-1:0] r_rd_ptr;
  logic [CW-1:0]      r_rlen, r_rcnt;
  logic               w_pop, w_re, w_done, w_hs, w_last, w_stream;
  logic [7:0]         w_rdata;

  // ---------------- write FSM: byte acceptance ----------------
  // Rising/falling edges of the frame window. r_fa_d resets high so that a
  // frame already in progress when reset releases never looks like a start.
  assign w_rise = bus.Rx_Frame_Active & ~r_fa_d;
  assign w_fall = ~bus.Rx_Frame_Active & r_fa_d;

  // In W_IDLE the candidate pointer tracks the committed pointer, so a byte
  // arriving on the rising-edge cycle lands at the committed pointer.
  assign w_base_ptr  = (r_wr_state == W_IDLE) ? r_wr_ptr : r_cand_ptr;
  assign w_base_cnt  = (r_wr_state == W_IDLE) ? '0 : r_cnt;
  assign w_free      = DEPTH_C - r_used;
  assign w_fifo_full = (r_fcnt == FIFO_FULL);
  assign w_fifo_empty = (r_fcnt == '0);

  always_comb begin
    w_wr_nxt   = r_wr_state;
    w_take     = 1'b0;
    w_we       = 1'b0;
    w_end_recv = 1'b0;
    w_end_drop = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (w_rise) begin
          w_wr_nxt = W_RECV;
          w_take   = bus.Rx_Byte_Rdy;
        end
      end
      W_RECV: begin
        if (w_fall) begin
          w_end_recv = 1'b1;
          w_wr_nxt   = W_IDLE;
        end else begin
          w_take = bus.Rx_Byte_Rdy;
        end
      end
      W_DROP: begin
        if (w_fall) begin
          w_end_drop = 1'b1;
          w_wr_nxt   = W_IDLE;
        end
      end
      default: w_wr_nxt = W_IDLE;
    endcase
    // A byte that would exceed the free space poisons the whole frame.
    if (w_take) begin
      if (w_base_cnt == w_free) w_wr_nxt = W_DROP;
      else                      w_we     = 1'b1;
    end
  end

  assign w_ok = w_end_recv & bus.Rx_Crc_Valid & (r_cnt >= MIN_CNT) & ~w_fifo_full;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_state <= W_IDLE;
      r_fa_d     <= 1'b1;
      r_cand_ptr <= '0;
      r_cnt      <= '0;
    end else begin
      r_wr_state <= w_wr_nxt;
      r_fa_d     <= bus.Rx_Frame_Active;
      if (w_we) begin
        r_cand_ptr <= w_base_ptr + 1'b1;
        r_cnt      <= w_base_cnt + 1'b1;
      end else if (r_wr_state == W_IDLE) begin
        r_cand_ptr <= r_wr_ptr;
        r_cnt      <= '0;
      end
    end
  end

  // ---------------- end-of-frame verdict stage (_p1) ----------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_commit <= 1'b0;
      r_drop   <= 1'b0;
      r_clen   <= '0;
    end else begin
      r_commit <= w_ok;
      r_drop   <= w_end_drop | (w_end_recv & ~w_ok);
      r_clen   <= r_cnt - FCS_C;
    end
  end

  // ---------------- committed pointer, length FIFO, occupancy ----------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_fwr    <= '0;
      r_frd    <= '0;
      r_fcnt   <= '0;
      r_used   <= '0;
      r_pend   <= '0;
    end else begin
      // The FCS is left behind the committed pointer and gets overwritten.
      if (r_commit) begin
        r_wr_ptr <= r_wr_ptr + r_clen[pADDR_W-1:0];
        r_fwr    <= r_fwr + 1'b1;
      end
      if (w_pop) r_frd <= r_frd + 1'b1;
      case ({r_commit, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
      r_used <= r_used + (r_commit ? r_clen : '0) - (w_done ? r_rlen : '0);
      case ({r_commit, w_done})
        2'b10:   r_pend <= r_pend + 1'b1;
        2'b01:   r_pend <= r_pend - 1'b1;
        default: r_pend <= r_pend;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (r_commit) r_lfifo[r_fwr] <= r_clen;
  end

  // ---------------- read FSM ----------------
  assign w_stream = (r_rd_state == R_STREAM);
  assign w_hs     = w_stream & bus.Frm_Tready;
  assign w_last   = (r_rcnt == r_rlen - 1'b1);

  always_comb begin
    w_rd_nxt = r_rd_state;
    w_pop    = 1'b0;
    w_re     = 1'b0;
    w_done   = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop    = 1'b1;
          w_rd_nxt = R_LOAD;
        end
      end
      R_LOAD: begin
        w_re     = 1'b1;
        w_rd_nxt = R_STREAM;
      end
      R_STREAM: begin
        // Prefetch the next byte on every handshake except the last, so the
        // stream sustains one byte per cycle and holds steady when stalled.
        if (w_hs) begin
          if (w_last) begin
            w_done   = 1'b1;
            w_rd_nxt = R_IDLE;
          end else begin
            w_re = 1'b1;
          end
        end
      end
      default: w_rd_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rd_state <= R_IDLE;
      r_rd_ptr   <= '0;
      r_rlen     <= '0;
      r_rcnt     <= '0;
    end else begin
      r_rd_state <= w_rd_nxt;
      if (w_re) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_pop) begin
        r_rlen <= r_lfifo[r_frd];
        r_rcnt <= '0;
      end else if (w_hs && !w_last) begin
        r_rcnt <= r_rcnt + 1'b1;
      end
    end
  end

  eth_rx_buf_ram #(
    .pADDR_W (pADDR_W)
  ) u_ram (
    .i_Clk   (Clk),
    .i_We    (w_we),
    .i_Waddr (w_base_ptr),
    .i_Wdata (bus.Rx_Byte),
    .i_Re    (w_re),
    .i_Raddr (r_rd_ptr),
    .o_Rdata (w_rdata)
  );

  // ---------------- output stage ----------------
  assign bus.Frm_Tvalid = w_stream;
  assign bus.Frm_Tdata  = w_stream ? w_rdata : 8'd0;
  assign bus.Frm_Tlast  = w_stream & w_last;
  assign Frm_Pending    = r_pend;
  assign Drop_Pulse     = r_drop;

`ifdef ETH_RX_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        r_ev_crc, r_ev_ovf;
  logic [15:0] r_good_cnt, r_crc_cnt, r_ovf_cnt;

  // Drop reasons are classified on the falling-edge cycle and counted one
  // cycle later, aligned with Drop_Pulse.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ev_crc   <= 1'b0;
      r_ev_ovf   <= 1'b0;
      r_good_cnt <= '0;
      r_crc_cnt  <= '0;
      r_ovf_cnt  <= '0;
    end else begin
      r_ev_crc <= (w_end_drop | (w_end_recv & ~w_ok)) & ~bus.Rx_Crc_Valid;
      r_ev_ovf <= w_end_drop | (w_end_recv & ~w_ok & w_fifo_full);
      if (r_commit) r_good_cnt <= sat_inc16(r_good_cnt);
      if (r_ev_crc) r_crc_cnt  <= sat_inc16(r_crc_cnt);
      if (r_ev_ovf) r_ovf_cnt  <= sat_inc16(r_ovf_cnt);
    end
  end

  assign Good_Cnt    = r_good_cnt;
  assign Crc_Err_Cnt = r_crc_cnt;
  assign Ovf_Cnt     = r_ovf_cnt;
`endif

endmodule
